ram_scratchpad_ctrl: RTL and testbench

- Parametrised successor to the lab data-register/scratchpad RAM block: one data register, a DEPTH-entry RAM, and a show-register output mux.
- Adds on-chip debouncing of the three push-button controls, with one action per press.
- Adds an auto-increment write/read pointer and a sequenced clear-all sweep.
- Sits between board switches/buttons and the LED/7-seg display logic.

---
 rtl/ram_scratchpad_ctrl.sv | 147 ++++++++++++++
 tb/tb_ram_scratchpad_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scratchpad_ctrl.sv
// Scratchpad controller: debounced buttons drive a data register, a DEPTH-entry
// RAM with an auto-increment pointer, and a sequenced clear-all sweep.

module ram_scratchpad_debounce #(
  parameter int DBC_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [DBC_W-1:0] cnt;

  // Level only flips after 2**DBC_W consecutive disagreeing cycles; the press
  // pulse is taken one flop after the level rises, giving one pulse per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      pulse   <= level & ~level_q;
      if (sync2 != level) begin
        if (cnt == {DBC_W{1'b1}}) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

module ram_scratchpad_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DBC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_btn,
  input  logic              write_btn,
  input  logic              clr_btn,
  input  logic              auto_inc,
  input  logic              show_reg,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic [ADDR_W-1:0] ptr,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] d_reg;
  logic [ADDR_W-1:0] sel_addr;
  logic              load_p;
  logic              write_p;
  logic              clr_p;
  logic              ram_we;
  logic [DATA_W-1:0] mem [DEPTH];

  ram_scratchpad_debounce #(.DBC_W(DBC_W)) u_dbc_load (
    .clk(clk), .rst(rst), .raw(load_btn), .pulse(load_p)
  );

  ram_scratchpad_debounce #(.DBC_W(DBC_W)) u_dbc_write (
    .clk(clk), .rst(rst), .raw(write_btn), .pulse(write_p)
  );

  ram_scratchpad_debounce #(.DBC_W(DBC_W)) u_dbc_clr (
    .clk(clk), .rst(rst), .raw(clr_btn), .pulse(clr_p)
  );

  assign sel_addr = auto_inc ? ptr : addr_in;
  assign ram_we   = (state == IDLE) && write_p && !clr_p;
  assign d_out    = show_reg ? d_reg : mem[sel_addr];

  // A clear request wins over a write in the same cycle; the write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
      d_reg   <= '0;
      ptr     <= '0;
      busy    <= 1'b0;
    end else begin
      if (load_p) begin
        d_reg <= d_in;
      end
      case (state)
        IDLE: begin
          if (clr_p) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end else if (write_p) begin
            ptr <= auto_inc ? ptr + 1'b1 : addr_in + 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == {ADDR_W{1'b1}}) begin
            state   <= IDLE;
            clr_cnt <= '0;
            ptr     <= '0;
            busy    <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (ram_we) begin
      mem[sel_addr] <= d_reg;
    end
  end

endmodule

// File: tb/tb_ram_scratchpad_ctrl.sv
// Directed bench for ram_scratchpad_ctrl with a short debounce (DBC_W=2, N=4),
// checking each step with immediate assertions against hand-computed values.

module tb_ram_scratchpad_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DBC_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_btn = 1'b0;
  logic              write_btn = 1'b0;
  logic              clr_btn = 1'b0;
  logic              auto_inc = 1'b0;
  logic              show_reg = 1'b0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [DATA_W-1:0] d_in = '0;
  logic [DATA_W-1:0] d_out;
  logic [ADDR_W-1:0] ptr;
  logic              busy;

  int checks = 0;
  int errors = 0;

  ram_scratchpad_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DBC_W(DBC_W)) dut (
    .clk(clk), .rst(rst), .load_btn(load_btn), .write_btn(write_btn),
    .clr_btn(clr_btn), .auto_inc(auto_inc), .show_reg(show_reg),
    .addr_in(addr_in), .d_in(d_in), .d_out(d_out), .ptr(ptr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold a button well past the debounce window, then release it cleanly.
  task automatic apply_stimulus(input int which);
    case (which)
      0: load_btn = 1'b1;
      1: write_btn = 1'b1;
      default: clr_btn = 1'b1;
    endcase
    tick(10);
    load_btn  = 1'b0;
    write_btn = 1'b0;
    clr_btn   = 1'b0;
    tick(10);
  endtask

  task automatic load_value(input logic [DATA_W-1:0] v);
    d_in = v;
    apply_stimulus(0);
  endtask

  task automatic manual_write(input logic [ADDR_W-1:0] a);
    auto_inc = 1'b0;
    addr_in  = a;
    apply_stimulus(1);
  endtask

  task automatic read_ram(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] v);
    show_reg = 1'b0;
    auto_inc = 1'b0;
    addr_in  = a;
    #1;
    v = d_out;
  endtask

  task automatic wait_busy(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic              ok;
    int                n;
    int                bad;

    // Reset state
    show_reg = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_output("reset_d_out", 32'(d_out), 32'h00);
    check_output("reset_ptr", 32'(ptr), 32'h00);
    check_output("reset_busy", 32'(busy), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);

    // 1. Bounce rejection
    load_value(8'h5A);
    show_reg = 1'b0;
    auto_inc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      write_btn = (i % 2 == 0);
      tick(2);
    end
    check_output("bounce_no_write", 32'(ptr), 32'h00);
    write_btn = 1'b1;
    tick(10);
    check_output("bounce_one_write", 32'(ptr), 32'h01);
    write_btn = 1'b0;
    tick(10);
    check_output("release_no_action", 32'(ptr), 32'h01);
    read_ram(6'h00, rd);
    check_output("bounce_ram0", 32'(rd), 32'h5A);

    // 2. Manual path, plus exact load latency
    show_reg = 1'b1;
    d_in     = 8'hA5;
    load_btn = 1'b1;
    tick(7);
    check_output("load_latency_before", 32'(d_out), 32'h5A);
    tick(1);
    check_output("load_latency_after", 32'(d_out), 32'hA5);
    load_btn = 1'b0;
    tick(10);
    manual_write(6'h3F);
    read_ram(6'h3F, rd);
    check_output("manual_ram3f", 32'(rd), 32'hA5);
    check_output("manual_ptr_wrap", 32'(ptr), 32'h00);

    // 3. Auto-increment wrap
    manual_write(6'h3E);
    check_output("ptr_after_3e", 32'(ptr), 32'h3F);
    load_value(8'h11);
    auto_inc = 1'b1;
    apply_stimulus(1);
    apply_stimulus(1);
    check_output("auto_ptr", 32'(ptr), 32'h01);
    read_ram(6'h3F, rd);
    check_output("auto_ram3f", 32'(rd), 32'h11);
    read_ram(6'h00, rd);
    check_output("auto_ram00", 32'(rd), 32'h11);

    // 4. Clear sweep with an ignored write press
    load_value(8'h22);
    manual_write(6'd5);
    load_value(8'h33);
    manual_write(6'd40);
    read_ram(6'd40, rd);
    check_output("preload_ram40", 32'(rd), 32'h33);
    check_output("preload_ptr", 32'(ptr), 32'd41);
    clr_btn = 1'b1;
    wait_busy(ok);
    check_output("clear_busy_rise", 32'(ok), 32'h1);
    clr_btn   = 1'b0;
    write_btn = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
      if (n == 10) write_btn = 1'b0;
    end
    check_output("clear_busy_cycles", 32'(n), 32'd64);
    tick(10);
    check_output("clear_ptr", 32'(ptr), 32'h00);
    check_output("clear_busy_low", 32'(busy), 32'h0);
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      read_ram(a[ADDR_W-1:0], rd);
      if (rd !== 8'h00) bad++;
    end
    check_output("clear_nonzero_reads", 32'(bad), 32'h0);

    // 5. Reset mid-clear
    load_value(8'h33);
    manual_write(6'd40);
    load_value(8'h44);
    manual_write(6'd10);
    load_value(8'h77);
    manual_write(6'd3);
    clr_btn = 1'b1;
    wait_busy(ok);
    check_output("reclear_busy_rise", 32'(ok), 32'h1);
    clr_btn = 1'b0;
    tick(10);
    rst      = 1'b0;
    show_reg = 1'b1;
    #1;
    check_output("midclr_busy", 32'(busy), 32'h0);
    check_output("midclr_d_reg", 32'(d_out), 32'h00);
    check_output("midclr_ptr", 32'(ptr), 32'h00);
    read_ram(6'd3, rd);
    check_output("midclr_ram3", 32'(rd), 32'h00);
    read_ram(6'd10, rd);
    check_output("midclr_ram10", 32'(rd), 32'h44);
    read_ram(6'd40, rd);
    check_output("midclr_ram40", 32'(rd), 32'h33);
    tick(2);
    rst = 1'b1;
    tick(2);

    // 6. Simultaneous load and write pulses
    load_value(8'h0F);
    d_in      = 8'hF0;
    auto_inc  = 1'b0;
    addr_in   = 6'd7;
    load_btn  = 1'b1;
    write_btn = 1'b1;
    tick(10);
    load_btn  = 1'b0;
    write_btn = 1'b0;
    tick(10);
    read_ram(6'd7, rd);
    check_output("simul_ram7", 32'(rd), 32'h0F);
    show_reg = 1'b1;
    #1;
    check_output("simul_d_reg", 32'(d_out), 32'hF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
